// File: rtl/puf_request_arbiter.sv
// puf_request_arbiter
// Shares one TERO-loop evaluation FSM among NUM_REQ requesters. A round-robin
// grant latches one challenge, the per-loop counts are captured and averaged
// while the FSM runs, then adjacent loop pairs are compared to build the
// response, which is returned with the requester ID over valid/ready.
module puf_request_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int NUM_LOOPS      = 4,
  parameter int CHALLENGE_BITS = 4,
  parameter int CNT_BITS       = 32,
  parameter int AVG_SHIFT      = 12,
  parameter int SEL_W          = $clog2(NUM_LOOPS-1)+1,
  parameter int ID_W           = $clog2(NUM_REQ)
) (
  input  logic                              clk_i,
  input  logic                              reset_i,
  input  logic [NUM_REQ-1:0]                req_valid_i,
  input  logic [NUM_REQ*CHALLENGE_BITS-1:0] req_challenge_i,
  output logic [NUM_REQ-1:0]                req_ready_o,
  output logic                              fsm_start_o,
  output logic [CHALLENGE_BITS-1:0]         fsm_challenge_o,
  input  logic                              fsm_done_i,
  input  logic                              fsm_store_i,
  input  logic [SEL_W-1:0]                  fsm_select_i,
  input  logic [CNT_BITS-1:0]               puf_count_i,
  output logic                              resp_valid_o,
  input  logic                              resp_ready_i,
  output logic [ID_W-1:0]                   resp_id_o,
  output logic [NUM_LOOPS/2-1:0]            resp_bits_o,
  output logic                              resp_err_o
);

  localparam int AVG_W  = CNT_BITS - AVG_SHIFT;
  localparam int LOOP_W = (NUM_LOOPS > 2) ? $clog2(NUM_LOOPS) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_CMP  = 2'd2;
  localparam logic [1:0] S_RESP = 2'd3;

  logic [1:0]                       state_q, state_d;
  logic [ID_W-1:0]                  ptr_q, ptr_d;
  logic [CHALLENGE_BITS-1:0]        chal_q;
  logic [ID_W-1:0]                  id_q;
  logic [NUM_LOOPS-1:0]             mask_q;
  logic [NUM_LOOPS-1:0][AVG_W-1:0]  avg_q;
  logic [NUM_LOOPS/2-1:0]           bits_q, bits_d;
  logic                             err_q;

  logic            gnt_found;
  logic [ID_W-1:0] gnt_idx;
  logic            grant;
  int              j;
  logic [ID_W-1:0] jj;
  logic            store_hit;
  logic [LOOP_W-1:0] sel_idx;

  // The dropped low count bits are intentionally discarded by the average.
  logic unused_cnt_lsb;
  assign unused_cnt_lsb = ^puf_count_i[AVG_SHIFT-1:0];

  // Round-robin search: first valid requester starting at the pointer.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    j         = 0;
    jj        = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      j  = (int'(ptr_q) + i) % NUM_REQ;
      jj = ID_W'(j);
      if (!gnt_found && req_valid_i[jj]) begin
        gnt_found = 1'b1;
        gnt_idx   = jj;
      end
    end
  end

  // A grant needs an idle arbiter and an FSM that has fully dropped done.
  assign grant = (state_q == S_IDLE) && !reset_i && !fsm_done_i && gnt_found;
  assign ptr_d = (gnt_idx == ID_W'(NUM_REQ-1)) ? '0 : gnt_idx + 1'b1;

  // One-hot accept pulse to the granted requester.
  always_comb begin
    req_ready_o = '0;
    if (grant) req_ready_o[gnt_idx] = 1'b1;
  end

  // Only in-range loop indices are captured; others are dropped silently.
  assign store_hit = (state_q == S_RUN) && fsm_store_i &&
                     ({{(32-SEL_W){1'b0}}, fsm_select_i} < 32'(NUM_LOOPS));
  assign sel_idx   = LOOP_W'(fsm_select_i);

  // Next-state logic for the grant / run / compare / respond sequence.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (grant)        state_d = S_RUN;
      S_RUN:   if (fsm_done_i)   state_d = S_CMP;
      S_CMP:                     state_d = S_RESP;
      S_RESP:  if (resp_ready_i) state_d = S_IDLE;
      default:                   state_d = S_IDLE;
    endcase
  end

  // Pairwise compare of averages; ties resolve to 0.
  always_comb begin
    bits_d = '0;
    for (int k = 0; k < NUM_LOOPS/2; k++)
      bits_d[k] = avg_q[2*k] > avg_q[2*k+1];
  end

  // Control state, round-robin pointer and per-grant latches.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      chal_q  <= '0;
      id_q    <= '0;
    end else begin
      state_q <= state_d;
      if (grant) begin
        ptr_q  <= ptr_d;
        chal_q <= req_challenge_i[gnt_idx*CHALLENGE_BITS +: CHALLENGE_BITS];
        id_q   <= gnt_idx;
      end
    end
  end

  // Capture averaged counts and track which loops were reported this run.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      mask_q <= '0;
      avg_q  <= '0;
    end else begin
      if (grant) mask_q <= '0;
      if (store_hit) begin
        mask_q[sel_idx] <= 1'b1;
        avg_q[sel_idx]  <= puf_count_i[CNT_BITS-1:AVG_SHIFT];
      end
    end
  end

  // Response bits and error flag are frozen in the single compare cycle.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      bits_q <= '0;
      err_q  <= 1'b0;
    end else if (state_q == S_CMP) begin
      bits_q <= bits_d;
      err_q  <= ~&mask_q;
    end
  end

  // Strobes are gated by reset so an aborted run never looks active.
  assign fsm_start_o     = (state_q == S_RUN)  && !reset_i;
  assign resp_valid_o    = (state_q == S_RESP) && !reset_i;
  assign fsm_challenge_o = chal_q;
  assign resp_id_o       = id_q;
  assign resp_bits_o     = bits_q;
  assign resp_err_o      = err_q;

endmodule
